// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 microsequencer: control-bit positions,
// the fetch control word, ROM entry layout and sequencer states.
package cpu_pkg;

  localparam int CW = 26;

  localparam int IRXI     = 0;
  localparam int PCXO     = 1;
  localparam int PCXI     = 2;
  localparam int PCINC    = 3;
  localparam int MARXI    = 4;
  localparam int MARXO    = 5;
  localparam int RAMXO    = 6;
  localparam int RAMXI    = 7;
  localparam int AXI      = 8;
  localparam int AXO      = 9;
  localparam int XXI      = 10;
  localparam int XXO      = 11;
  localparam int YXI      = 12;
  localparam int YXO      = 13;
  localparam int SPXI     = 14;
  localparam int SPXO     = 15;
  localparam int SPINC    = 16;
  localparam int SPDEC    = 17;
  localparam int PXI      = 18;
  localparam int PXO      = 19;
  localparam int ALUXO    = 20;
  localparam int TXI      = 21;
  localparam int TXO      = 22;
  localparam int CARRY_IN = 23;
  localparam int ADDRHI   = 24;
  localparam int SUBTRACT = 25;

  localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Fetch: PC onto the address bus, memory onto the data bus, IR loads, PC advances.
  localparam logic [CW-1:0] FETCH_WORD = (CW_ONE << PCXO) | (CW_ONE << RAMXO) |
                                         (CW_ONE << IRXI) | (CW_ONE << PCINC);

  localparam logic [7:0] NOP_OPCODE = 8'hEA;

  typedef struct packed {
    logic          last;
    logic          legal;
    logic [CW-1:0] word;
  } rom_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    JAM   = 2'd2
  } state_t;

  function automatic logic [CW-1:0] cb(input int unsigned idx);
    logic [CW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/micro_rom.sv
// Microcode ROM: combinational (opcode, step) -> {last, legal, word}.
// Opcodes not listed are illegal and return an all-zero entry.
module micro_rom #(
  parameter int STEP_W = 3
) (
  input  logic [7:0]            i_opcode,
  input  logic [STEP_W-1:0]     i_step,
  output cpu_pkg::rom_entry_t   o_entry
);
  import cpu_pkg::*;

  int unsigned w_k;
  assign w_k = {{(32-STEP_W){1'b0}}, i_step};

  // Table lookup; every path starts from an illegal, empty entry.
  always_comb begin
    o_entry = '0;
    casez (i_opcode)
      8'hEA: begin // NOP
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.last = 1'b1;
          default: ;
        endcase
      end
      8'hAA: begin // TAX
        o_entry.legal = 1'b1;
        case (w_k)
          1: begin o_entry.word = cb(AXO) | cb(XXI); o_entry.last = 1'b1; end
          default: ;
        endcase
      end
      8'hE8: begin // INX
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(XXO) | cb(TXI);
          2: begin o_entry.word = cb(ALUXO) | cb(CARRY_IN) | cb(XXI); o_entry.last = 1'b1; end
          default: ;
        endcase
      end
      8'hA9: begin // LDA #imm
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(PCXO) | cb(MARXI);
          2: begin o_entry.word = cb(RAMXO) | cb(AXI) | cb(PCINC); o_entry.last = 1'b1; end
          default: ;
        endcase
      end
      8'hE9: begin // SBC #imm
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(PCXO) | cb(MARXI);
          2: o_entry.word = cb(RAMXO) | cb(TXI) | cb(PCINC);
          3: begin
            o_entry.word = cb(AXO) | cb(TXO) | cb(SUBTRACT) | cb(CARRY_IN) | cb(ALUXO) | cb(AXI);
            o_entry.last = 1'b1;
          end
          default: ;
        endcase
      end
      8'h4C: begin // JMP abs
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(PCXO) | cb(MARXI);
          2: o_entry.word = cb(RAMXO) | cb(TXI) | cb(PCINC);
          3: begin o_entry.word = cb(TXO) | cb(PCXI) | cb(ADDRHI); o_entry.last = 1'b1; end
          default: ;
        endcase
      end
      8'h8D: begin // STA abs
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(PCXO) | cb(MARXI) | cb(PCINC);
          2: o_entry.word = cb(RAMXO) | cb(TXI) | cb(PCINC);
          3: o_entry.word = cb(TXO) | cb(MARXI) | cb(ADDRHI);
          4: begin o_entry.word = cb(AXO) | cb(RAMXI); o_entry.last = 1'b1; end
          default: ;
        endcase
      end
      8'h00: begin // BRK
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(PCINC);
          2: o_entry.word = cb(SPXO) | cb(MARXI);
          3: o_entry.word = cb(PCXO) | cb(ADDRHI) | cb(RAMXI) | cb(SPDEC);
          4: o_entry.word = cb(PCXO) | cb(RAMXI) | cb(SPDEC);
          5: o_entry.word = cb(PXO) | cb(RAMXI) | cb(SPDEC);
          6: begin o_entry.word = cb(PCXI) | cb(ADDRHI) | cb(RAMXO); o_entry.last = 1'b1; end
          default: ;
        endcase
      end
      8'h6C: begin // JMP (ind): no last flag, ends at the final step
        o_entry.legal = 1'b1;
        case (w_k)
          1: o_entry.word = cb(PCXO) | cb(MARXI);
          2: o_entry.word = cb(RAMXO) | cb(TXI) | cb(PCINC);
          3: o_entry.word = cb(PCXO) | cb(MARXI);
          4: o_entry.word = cb(RAMXO) | cb(ADDRHI) | cb(TXI);
          5: o_entry.word = cb(TXO) | cb(MARXI);
          6: o_entry.word = cb(RAMXO) | cb(PCXI);
          7: o_entry.word = cb(ADDRHI) | cb(RAMXO) | cb(PCXI);
          default: ;
        endcase
      end
      default: o_entry = '0;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// 6502 microsequencer: fetch/execute/jam FSM, step counter and IR, with
// RDY stalling and a gated per-cycle control word.
module microsequencer #(
  parameter int CW     = cpu_pkg::CW,
  parameter int STEPS  = 8,
  parameter int STEP_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        opcode_in,
  output logic [CW-1:0]     control_signals,
  output logic [STEP_W-1:0] step,
  output logic [7:0]        ir,
  output logic              sync,
  output logic              jam
);
  import cpu_pkg::*;

  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  state_t                r_state, w_state_nxt;
  logic [STEP_W-1:0]     r_step,  w_step_nxt;
  logic [7:0]            r_ir,    w_ir_nxt;
  rom_entry_t            w_rom;
  logic [cpu_pkg::CW-1:0] w_word;
  logic                  w_gate;

  micro_rom #(.STEP_W(STEP_W)) u_rom (
    .i_opcode (r_ir),
    .i_step   (r_step),
    .o_entry  (w_rom)
  );

  // State, step and IR registers; reset overrides rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_step  <= '0;
      r_ir    <= NOP_OPCODE;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  // Next state: everything holds unless rdy is high; JAM never leaves on its own.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_ir_nxt    = r_ir;
    if (rdy) begin
      case (r_state)
        FETCH: begin
          w_ir_nxt    = opcode_in;
          w_step_nxt  = STEP_ONE;
          w_state_nxt = EXEC;
        end
        EXEC: begin
          if (!w_rom.legal && (r_step == STEP_ONE)) begin
            w_state_nxt = JAM;
          end else if (w_rom.last || (r_step == STEP_LAST)) begin
            w_step_nxt  = '0;
            w_state_nxt = FETCH;
          end else begin
            w_step_nxt  = r_step + STEP_ONE;
          end
        end
        JAM: ;
        default: begin
          w_step_nxt  = '0;
          w_state_nxt = FETCH;
        end
      endcase
    end
  end

  // Output decode from registered state, then gated by rst, stall and jam.
  always_comb begin
    w_word = '0;
    case (r_state)
      FETCH:   w_word = FETCH_WORD;
      EXEC:    w_word = w_rom.word;
      default: w_word = '0;
    endcase
  end

  assign w_gate          = rst || !rdy || (r_state == JAM);
  assign control_signals = w_gate ? '0 : CW'(w_word);
  assign step            = r_step;
  assign ir              = r_ir;
  assign sync            = (r_state == FETCH);
  assign jam             = (r_state == JAM);

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against an instruction-level model.
module tb_microsequencer;
  import cpu_pkg::*;

  localparam int STEPS  = 8;
  localparam int STEP_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic [7:0]        opcode_in = 8'hEA;
  logic [CW-1:0]     control_signals;
  logic [STEP_W-1:0] step;
  logic [7:0]        ir;
  logic              sync;
  logic              jam;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Instruction-level model state: position within the instruction (0 = fetch).
  int unsigned m_pos = 0;
  logic [7:0]  m_ir  = 8'hEA;
  bit          m_jam = 1'b0;

  microsequencer #(.CW(CW), .STEPS(STEPS), .STEP_W(STEP_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .opcode_in       (opcode_in),
    .control_signals (control_signals),
    .step            (step),
    .ir              (ir),
    .sync            (sync),
    .jam             (jam)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] bm(input int unsigned i);
    logic [CW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Instruction length in exec steps (0 = no last flag).
  function automatic int unsigned ref_last(input logic [7:0] op);
    case (op)
      8'hEA, 8'hAA:        return 1;
      8'hE8, 8'hA9:        return 2;
      8'hE9, 8'h4C:        return 3;
      8'h8D:               return 4;
      8'h00:               return 6;
      default:             return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [7:0] op);
    case (op)
      8'hEA, 8'hAA, 8'hE8, 8'hA9, 8'hE9, 8'h4C, 8'h8D, 8'h00, 8'h6C: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned ref_len(input logic [7:0] op);
    int unsigned l;
    l = ref_last(op);
    if (l == 0 || l > STEPS - 1) l = STEPS - 1;
    return l;
  endfunction

  function automatic logic [CW-1:0] ref_word(input logic [7:0] op, input int unsigned k);
    logic [CW-1:0] w;
    w = '0;
    case (op)
      8'hAA: if (k == 1) w = bm(AXO) | bm(XXI);
      8'hE8: case (k)
        1: w = bm(XXO) | bm(TXI);
        2: w = bm(ALUXO) | bm(CARRY_IN) | bm(XXI);
        default: ;
      endcase
      8'hA9: case (k)
        1: w = bm(PCXO) | bm(MARXI);
        2: w = bm(RAMXO) | bm(AXI) | bm(PCINC);
        default: ;
      endcase
      8'hE9: case (k)
        1: w = bm(PCXO) | bm(MARXI);
        2: w = bm(RAMXO) | bm(TXI) | bm(PCINC);
        3: w = bm(AXO) | bm(TXO) | bm(SUBTRACT) | bm(CARRY_IN) | bm(ALUXO) | bm(AXI);
        default: ;
      endcase
      8'h4C: case (k)
        1: w = bm(PCXO) | bm(MARXI);
        2: w = bm(RAMXO) | bm(TXI) | bm(PCINC);
        3: w = bm(TXO) | bm(PCXI) | bm(ADDRHI);
        default: ;
      endcase
      8'h8D: case (k)
        1: w = bm(PCXO) | bm(MARXI) | bm(PCINC);
        2: w = bm(RAMXO) | bm(TXI) | bm(PCINC);
        3: w = bm(TXO) | bm(MARXI) | bm(ADDRHI);
        4: w = bm(AXO) | bm(RAMXI);
        default: ;
      endcase
      8'h00: case (k)
        1: w = bm(PCINC);
        2: w = bm(SPXO) | bm(MARXI);
        3: w = bm(PCXO) | bm(ADDRHI) | bm(RAMXI) | bm(SPDEC);
        4: w = bm(PCXO) | bm(RAMXI) | bm(SPDEC);
        5: w = bm(PXO) | bm(RAMXI) | bm(SPDEC);
        6: w = bm(PCXI) | bm(ADDRHI) | bm(RAMXO);
        default: ;
      endcase
      8'h6C: case (k)
        1: w = bm(PCXO) | bm(MARXI);
        2: w = bm(RAMXO) | bm(TXI) | bm(PCINC);
        3: w = bm(PCXO) | bm(MARXI);
        4: w = bm(RAMXO) | bm(ADDRHI) | bm(TXI);
        5: w = bm(TXO) | bm(MARXI);
        6: w = bm(RAMXO) | bm(PCXI);
        7: w = bm(ADDRHI) | bm(RAMXO) | bm(PCXI);
        default: ;
      endcase
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic [7:0] op);
    @(negedge clk);
    rst = r;
    rdy = d;
    opcode_in = op;
    #1;
  endtask

  // Compare all outputs against the instruction-level model for this cycle.
  task automatic check_model(input string tag);
    logic [CW-1:0] ecw;
    if (rst || !rdy || m_jam) ecw = '0;
    else if (m_pos == 0)      ecw = FETCH_WORD;
    else                      ecw = ref_word(m_ir, m_pos);
    chk({tag, ".step"}, 32'(step), m_pos);
    chk({tag, ".sync"}, 32'(sync), 32'(!m_jam && m_pos == 0));
    chk({tag, ".jam"},  32'(jam),  32'(m_jam));
    chk({tag, ".ir"},   32'(ir),   32'(m_ir));
    chk({tag, ".cw"},   32'(control_signals), 32'(ecw));
  endtask

  // Advance one clock and step the model with the inputs applied this cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pos = 0; m_ir = 8'hEA; m_jam = 1'b0;
    end else if (rdy && !m_jam) begin
      if (m_pos == 0) begin
        m_ir = opcode_in; m_pos = 1;
      end else if (!ref_legal(m_ir)) begin
        m_jam = 1'b1;
      end else if (m_pos >= ref_len(m_ir)) begin
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic d, input logic [7:0] op, input string tag);
    drive(r, d, op);
    check_model(tag);
    tick();
  endtask

  // Cycles from a fetch of op until the next fetch, bounded.
  task automatic measure(input logic [7:0] op, input string tag, output int unsigned n);
    cyc(1'b1, 1'b1, 8'hEA, {tag, ".rst"});
    cyc(1'b0, 1'b1, op, {tag, ".fetch"});
    n = 0;
    while (n < 20) begin
      n++;
      drive(1'b0, 1'b1, 8'hEA);
      if (sync === 1'b1) break;
      check_model(tag);
      tick();
    end
    check_model(tag);
    tick();
  endtask

  typedef struct {
    logic              r;
    logic              d;
    logic [7:0]        op;
    logic [STEP_W-1:0] e_step;
    logic              e_sync;
    logic              e_jam;
    logic [7:0]        e_ir;
    logic [CW-1:0]     e_cw;
  } vec_t;

  vec_t vt[14];
  logic [7:0] known[9];

  initial begin
    logic [CW-1:0] lda1, lda2;
    int unsigned   n;
    logic          r, d;
    logic [7:0]    op;

    lda1 = bm(PCXO) | bm(MARXI);
    lda2 = bm(RAMXO) | bm(AXI) | bm(PCINC);
    known = '{8'hEA, 8'hAA, 8'hE8, 8'hA9, 8'hE9, 8'h4C, 8'h8D, 8'h00, 8'h6C};

    // Reset/NOP, LDA #imm, and a 3-cycle stall at step 1 plus a stalled fetch.
    vt[0]  = '{1'b1, 1'b1, 8'hEA, 3'd0, 1'b1, 1'b0, 8'hEA, '0};
    vt[1]  = '{1'b0, 1'b1, 8'hEA, 3'd0, 1'b1, 1'b0, 8'hEA, FETCH_WORD};
    vt[2]  = '{1'b0, 1'b1, 8'hA9, 3'd1, 1'b0, 1'b0, 8'hEA, '0};
    vt[3]  = '{1'b0, 1'b1, 8'hA9, 3'd0, 1'b1, 1'b0, 8'hEA, FETCH_WORD};
    vt[4]  = '{1'b0, 1'b1, 8'hEA, 3'd1, 1'b0, 1'b0, 8'hA9, lda1};
    vt[5]  = '{1'b0, 1'b1, 8'hEA, 3'd2, 1'b0, 1'b0, 8'hA9, lda2};
    vt[6]  = '{1'b0, 1'b1, 8'hA9, 3'd0, 1'b1, 1'b0, 8'hA9, FETCH_WORD};
    vt[7]  = '{1'b0, 1'b0, 8'hEA, 3'd1, 1'b0, 1'b0, 8'hA9, '0};
    vt[8]  = '{1'b0, 1'b0, 8'hEA, 3'd1, 1'b0, 1'b0, 8'hA9, '0};
    vt[9]  = '{1'b0, 1'b0, 8'hEA, 3'd1, 1'b0, 1'b0, 8'hA9, '0};
    vt[10] = '{1'b0, 1'b1, 8'hEA, 3'd1, 1'b0, 1'b0, 8'hA9, lda1};
    vt[11] = '{1'b0, 1'b1, 8'hEA, 3'd2, 1'b0, 1'b0, 8'hA9, lda2};
    vt[12] = '{1'b0, 1'b0, 8'hEA, 3'd0, 1'b1, 1'b0, 8'hA9, '0};
    vt[13] = '{1'b0, 1'b1, 8'hEA, 3'd0, 1'b1, 1'b0, 8'hA9, FETCH_WORD};

    drive(1'b1, 1'b1, 8'hEA);
    tick();

    for (int unsigned i = 0; i < 14; i++) begin
      drive(vt[i].r, vt[i].d, vt[i].op);
      chk($sformatf("vec%0d.step", i), 32'(step), 32'(vt[i].e_step));
      chk($sformatf("vec%0d.sync", i), 32'(sync), 32'(vt[i].e_sync));
      chk($sformatf("vec%0d.jam", i),  32'(jam),  32'(vt[i].e_jam));
      chk($sformatf("vec%0d.ir", i),   32'(ir),   32'(vt[i].e_ir));
      chk($sformatf("vec%0d.cw", i),   32'(control_signals), 32'(vt[i].e_cw));
      tick();
    end

    // Illegal opcode: step-1 word is 0, then JAM with rdy ignored until reset.
    cyc(1'b1, 1'b1, 8'hEA, "ill.rst");
    cyc(1'b0, 1'b1, 8'h02, "ill.fetch");
    drive(1'b0, 1'b1, 8'hEA);
    chk("ill.s1.cw",  32'(control_signals), 32'd0);
    chk("ill.s1.jam", 32'(jam), 32'd0);
    chk("ill.s1.step", 32'(step), 32'd1);
    tick();
    for (int unsigned i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      chk("ill.jam",  32'(jam), 32'd1);
      chk("ill.step", 32'(step), 32'd1);
      chk("ill.cw",   32'(control_signals), 32'd0);
      check_model("ill");
      tick();
    end
    drive(1'b1, 1'b0, 8'hEA);
    chk("ill.rstcyc.cw", 32'(control_signals), 32'd0);
    tick();
    drive(1'b0, 1'b1, 8'hEA);
    chk("ill.after.step", 32'(step), 32'd0);
    chk("ill.after.ir",   32'(ir), 32'hEA);
    chk("ill.after.jam",  32'(jam), 32'd0);
    chk("ill.after.sync", 32'(sync), 32'd1);
    check_model("ill.after");
    tick();

    // Long instruction and forced end at the final step.
    measure(8'h00, "brk", n);
    chk("brk.cycles", n, 32'd7);
    measure(8'h6C, "forced", n);
    chk("forced.cycles", n, 32'd8);
    measure(8'hA9, "lda", n);
    chk("lda.cycles", n, 32'd3);

    // Reset at step 2 of BRK.
    cyc(1'b1, 1'b1, 8'hEA, "rmid.rst");
    cyc(1'b0, 1'b1, 8'h00, "rmid.fetch");
    cyc(1'b0, 1'b1, 8'hEA, "rmid.s1");
    drive(1'b1, 1'b1, 8'hEA);
    chk("rmid.s2.step", 32'(step), 32'd2);
    chk("rmid.s2.cw",   32'(control_signals), 32'd0);
    check_model("rmid.s2");
    tick();
    drive(1'b0, 1'b1, 8'hEA);
    chk("rmid.next.step", 32'(step), 32'd0);
    chk("rmid.next.sync", 32'(sync), 32'd1);
    chk("rmid.next.ir",   32'(ir), 32'hEA);
    chk("rmid.next.cw",   32'(control_signals), 32'(FETCH_WORD));
    check_model("rmid.next");
    tick();

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2) || (m_jam && $urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 99) < 80);
      op = ($urandom_range(0, 9) < 8) ? known[$urandom_range(0, 8)] : 8'($urandom_range(0, 255));
      cyc(r, d, op, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Sequential successor to the combinational opcode/step decoder of the 6502 core. It owns the microcode step counter, the instruction register and a fetch/execute/jam state machine, and produces the per-cycle control word that drives register enables, ALU selects and bus steering. It is parametrised in control-word width and step depth. It adds RDY stalling, variable-length instructions via an end-of-instruction flag, and a jam state for illegal opcodes.

## Interface
Parameters:
- CW, 26, control-word width; bit positions come from the shared package.
- STEPS, 8, maximum steps per instruction, fetch included; power of two.
- STEP_W, $clog2(STEPS), step counter width.
- FETCH_WORD, package constant, control word driven during the fetch step (PC onto address bus, IR load enable).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  memory ready; low stalls the sequencer.
- opcode_in  in  8  data bus; sampled as the opcode at the end of fetch.
- control_signals  out  CW  control word for the current cycle.
- step  out  STEP_W  current microcode step; 0 is fetch.
- ir  out  8  latched opcode.
- sync  out  1  high during a fetch step (6502 SYNC semantics).
- jam  out  1  high while in JAM.

## Operation
- States:
  - FETCH: step 0.
  - EXEC: step 1..STEPS-1.
  - JAM: terminal.
- ROM entry: micro_rom(ir, step) returns {last, legal, word[CW-1:0]}.
- FETCH with rdy=1:
  - ir <= opcode_in.
  - step <= 1.
  - state <= EXEC.
- EXEC with rdy=1:
  - legal=0 at step 1: enter JAM.
  - Otherwise, last=1, or step==STEPS-1 (forced end): step <= 0, state <= FETCH.
  - Otherwise step <= step+1.
- The step counter never wraps through a non-fetch value. Forced end at STEPS-1 behaves exactly as last=1.
- JAM:
  - control_signals=0, jam=1, step held at 1.
  - Only rst exits; rdy is ignored.
- rdy=0 in any state:
  - state, step and ir hold.
  - control_signals forced to 0, so no register load or ALU op repeats or half-commits.
  - sync still reflects state.
- Output decode is combinational from registered state:
  - FETCH: control_signals=FETCH_WORD.
  - EXEC: control_signals=ROM word.
  - Then the rdy/rst/jam gate is applied.
- Reset values:
  - state=FETCH, step=0, ir=8'hEA (NOP), jam=0.
  - control_signals=0 while rst=1.
  - sync=1 once rst falls.

## Timing
- All state updates happen on the rising clk edge, only when rdy=1 (rst overrides rdy).
- control_signals is valid in the same cycle as step; there are no output registers.
- An instruction with last at exec step N takes N+1 cycles plus the number of rdy-low cycles. The minimum is 2 cycles (N=1).
- opcode_in is sampled on the edge that ends a FETCH cycle with rdy=1. The ROM word for step 1 appears in the following cycle.
- rst during EXEC or JAM: the next cycle is FETCH with step=0 and ir=8'hEA. The interrupted instruction has no further effect.
- rst and rdy=0 together: reset wins.
- JAM entry: the step-1 cycle of an illegal opcode outputs its ROM word, which the ROM holds at 0. jam=1 from the next cycle.

## Structure
- Shared package cpu_pkg holds:
  - control-bit index constants (IRXI..SUBTRACT) and CW;
  - FETCH_WORD;
  - the ROM entry typedef {last, legal, word};
  - the state enum {FETCH, EXEC, JAM};
  - the NOP opcode constant.
- Sub-module micro_rom: purely combinational (opcode, step) -> entry, with casez table, default legal=0. The sequencer instantiates it once.
- The sequencer itself holds the state register, step counter, IR, and the output gating.

## Test plan
- Reset then NOP:
  - rst 1 cycle, rdy=1, opcode_in=8'hEA.
  - Required: step 0,1,0,…; sync=1,0,1.
  - control_signals = FETCH_WORD, then 0, then FETCH_WORD.
- LDA immediate:
  - opcode_in=8'hA9 at fetch.
  - Required: ir=8'hA9; step 0,1,2,0 (last at step 2).
  - control_signals matches the micro_rom entries for 8'hA9 steps 1 and 2; 3 cycles total.
- RDY stall:
  - 8'hA9 with rdy=0 for 3 cycles at step 1.
  - Required: step stays 1 and control_signals=0 for those 3 cycles, then the step-1 word appears once.
  - 6 cycles total.
- Illegal opcode:
  - opcode_in=8'h02.
  - Required: jam=1 from the second cycle after fetch; step stuck at 1; control_signals=0 for 20 further cycles regardless of rdy.
  - After rst: step=0, ir=8'hEA, jam=0.
- Long instruction and forced end:
  - BRK 8'h00 (last at step 6) completes in 7 cycles.
  - A ROM entry with no last flag returns to FETCH after step 7 (8 cycles).
- Reset mid-instruction:
  - Assert rst at step 2 of 8'h00.
  - Required: next cycle step=0, sync=1, ir=8'hEA, control_signals=0 during the rst cycle.
